// File: rtl/mcu_spi_src_mux_pkg.sv
// Shared types and helpers for the MCU SPI source selector.
package mcu_spi_src_mux_pkg;

    typedef enum logic [1:0] {
        SEL   = 2'd0,
        PEND  = 2'd1,
        BLANK = 2'd2
    } spi_mux_state_t;

    localparam int SYNC_STAGES = 2;

    // Width of the source index; never narrower than one bit.
    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mcu_spi_src_mux_if.sv
// SPI bundle between the MCU sources, the selector and the core-side port.
interface mcu_spi_src_mux_if #(
    parameter int N_SRC = 2
);
    logic [N_SRC-1:0] src_sclk;
    logic [N_SRC-1:0] src_csn;
    logic [N_SRC-1:0] src_mosi;
    logic [N_SRC-1:0] src_miso;
    logic [N_SRC-1:0] src_intn;
    logic             mcu_sclk;
    logic             mcu_csn;
    logic             mcu_mosi;
    logic             mcu_miso;
    logic             mcu_intn;

    // Environment side: MCU sources and the core.
    modport master (
        output src_sclk, src_csn, src_mosi, mcu_miso, mcu_intn,
        input  src_miso, src_intn, mcu_sclk, mcu_csn, mcu_mosi
    );

    // Selector side.
    modport slave (
        input  src_sclk, src_csn, src_mosi, mcu_miso, mcu_intn,
        output src_miso, src_intn, mcu_sclk, mcu_csn, mcu_mosi
    );
endinterface

// File: rtl/mcu_spi_src_mux_csn_claim_filter.sv
// Per-source csn synchronizer plus saturating low-run counter.
// run_full rises once csn has been seen low for MIN_LOW synced cycles.
module mcu_spi_src_mux_csn_claim_filter
    import mcu_spi_src_mux_pkg::*;
#(
    parameter int MIN_LOW = 4
) (
    input  logic clk32,
    input  logic por,
    input  logic csn,
    output logic csn_s,
    output logic run_full
);
    localparam int RW = $clog2(MIN_LOW + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(MIN_LOW);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [RW-1:0]          run;

    // Sync flops reset to idle (high); any synced high restarts the run.
    always_ff @(posedge clk32 or posedge por) begin
        if (por) begin
            sync_q <= '1;
            run    <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], csn};
            if (sync_q[SYNC_STAGES-1])
                run <= '0;
            else if (run != RUN_MAX)
                run <= run + 1'b1;
        end
    end

    assign csn_s    = sync_q[SYNC_STAGES-1];
    assign run_full = (run == RUN_MAX);

endmodule

// File: rtl/mcu_spi_src_mux.sv
// Selects one of N_SRC MCU SPI sources for the core. A source claims the bus by
// holding csn low; the switch happens only once the current source is idle, and
// the claiming transaction is blanked so the core only sees whole transactions.
module mcu_spi_src_mux
    import mcu_spi_src_mux_pkg::*;
#(
    parameter int N_SRC       = 2,
    parameter int DEFAULT_SRC = 0,
    parameter int STICKY      = 1,
    parameter int TIMEOUT_W   = 24,
    parameter int MIN_LOW     = 4,
    parameter int BROADCAST   = 1
) (
    input  logic                      clk32,
    input  logic                      por,
    mcu_spi_src_mux_if.slave          bus,
    output logic [sel_w(N_SRC)-1:0]   sel,
    output logic                      switched
);
    localparam int SW = sel_w(N_SRC);
    localparam logic [SW-1:0]        DEF_SEL = SW'(DEFAULT_SRC);
    // Last timer value before the idle count reaches 2**TIMEOUT_W-1.
    localparam logic [TIMEOUT_W-1:0] T_LAST  = ~TIMEOUT_W'(1);

    spi_mux_state_t       state;
    logic [SW-1:0]        cand;
    logic                 blank;
    logic [TIMEOUT_W-1:0] timer;

    logic [N_SRC-1:0]     csn_s;
    logic [N_SRC-1:0]     run_full;
    logic [N_SRC-1:0]     claim;
    logic                 claim_any;
    logic [SW-1:0]        claim_hi;

    for (genvar i = 0; i < N_SRC; i++) begin : g_filt
        mcu_spi_src_mux_csn_claim_filter #(.MIN_LOW(MIN_LOW)) u_filt (
            .clk32    (clk32),
            .por      (por),
            .csn      (bus.src_csn[i]),
            .csn_s    (csn_s[i]),
            .run_full (run_full[i])
        );
        assign claim[i] = run_full[i] && (SW'(i) != sel);
    end

    // Highest claiming index wins.
    always_comb begin
        claim_hi = '0;
        for (int i = 0; i < N_SRC; i++)
            if (claim[i]) claim_hi = SW'(i);
        claim_any = |claim;
    end

    // Selection FSM; timer only advances in SEL on a non-default source.
    always_ff @(posedge clk32 or posedge por) begin
        if (por) begin
            state    <= SEL;
            sel      <= DEF_SEL;
            cand     <= DEF_SEL;
            blank    <= 1'b0;
            switched <= 1'b0;
            timer    <= '0;
        end else begin
            switched <= 1'b0;
            case (state)
                SEL: begin
                    if (claim_any) begin
                        cand  <= claim_hi;
                        state <= PEND;
                        timer <= '0;
                    end else if (STICKY == 0 && sel != DEF_SEL) begin
                        if (!csn_s[sel]) begin
                            timer <= '0;
                        end else if (timer == T_LAST) begin
                            // Default source is idle by definition: no blank.
                            sel      <= DEF_SEL;
                            switched <= 1'b1;
                            timer    <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end else begin
                        timer <= '0;
                    end
                end
                PEND: begin
                    timer <= '0;
                    if (csn_s[sel]) begin
                        sel      <= cand;
                        blank    <= 1'b1;
                        switched <= 1'b1;
                        state    <= BLANK;
                    end else if (!claim[cand]) begin
                        state <= SEL;
                    end
                end
                BLANK: begin
                    timer <= '0;
                    if (csn_s[sel]) begin
                        blank <= 1'b0;
                        state <= SEL;
                    end
                end
                default: state <= SEL;
            endcase
        end
    end

    assign bus.mcu_sclk = bus.src_sclk[sel];
    assign bus.mcu_mosi = bus.src_mosi[sel];
    assign bus.mcu_csn  = bus.src_csn[sel] | blank;

    // Return path: broadcast, or idle-high to unselected sources.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            bus.src_miso[i] = (BROADCAST != 0 || SW'(i) == sel) ? bus.mcu_miso : 1'b1;
            bus.src_intn[i] = (BROADCAST != 0 || SW'(i) == sel) ? bus.mcu_intn : 1'b1;
        end
    end

endmodule

// File: tb/tb_mcu_spi_src_mux.sv
// Directed scenarios followed by random csn traffic, checked every cycle
// against a history-based reference model of the selection rules.
module tb_mcu_spi_src_mux;
    localparam int N       = 4;
    localparam int MIN_LOW = 4;
    localparam int TOUT    = 15;   // 2**4-1 idle cycles

    logic       clk32 = 1'b0;
    logic       por   = 1'b1;
    logic [1:0] sel;
    logic       switched;

    mcu_spi_src_mux_if #(.N_SRC(N)) bus ();

    mcu_spi_src_mux #(
        .N_SRC(N), .DEFAULT_SRC(0), .STICKY(0), .TIMEOUT_W(4),
        .MIN_LOW(MIN_LOW), .BROADCAST(0)
    ) dut (
        .clk32    (clk32),
        .por      (por),
        .bus      (bus),
        .sel      (sel),
        .switched (switched)
    );

    always #5 clk32 = ~clk32;

    int checks = 0;
    int errors = 0;

    // Reference model: h[i][k] = raw csn of source i sampled k edges ago.
    logic [7:0] h [N];
    int  m_sel, m_cand, m_mode, m_tcnt;   // m_mode: 0 idle, 1 waiting, 2 masking
    bit  m_blank, m_sw;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < N; i++) h[i] = '1;
        m_sel = 0; m_cand = 0; m_mode = 0; m_tcnt = 0; m_blank = 0; m_sw = 0;
    endtask

    task automatic mdl_edge();
        bit sy [N];
        bit cl [N];
        bit any;
        int hi;
        if (por) begin
            mdl_reset();
            return;
        end
        for (int i = 0; i < N; i++) h[i] = {h[i][6:0], bus.src_csn[i]};
        any = 0; hi = 0;
        for (int i = 0; i < N; i++) begin
            sy[i] = h[i][2];
            cl[i] = (i != m_sel);
            for (int k = 3; k < 3 + MIN_LOW; k++) if (h[i][k]) cl[i] = 0;
            if (cl[i]) begin any = 1; hi = i; end
        end
        m_sw = 0;
        if (m_mode == 0) begin
            if (any) begin
                m_cand = hi; m_mode = 1; m_tcnt = 0;
            end else if (m_sel != 0) begin
                if (sy[m_sel]) begin
                    m_tcnt++;
                    if (m_tcnt == TOUT) begin m_sel = 0; m_sw = 1; m_tcnt = 0; end
                end else m_tcnt = 0;
            end else m_tcnt = 0;
        end else if (m_mode == 1) begin
            m_tcnt = 0;
            if (sy[m_sel]) begin
                m_sel = m_cand; m_blank = 1; m_sw = 1; m_mode = 2;
            end else if (!cl[m_cand]) m_mode = 0;
        end else begin
            m_tcnt = 0;
            if (sy[m_sel]) begin m_blank = 0; m_mode = 0; end
        end
    endtask

    task automatic mdl_check();
        logic [N-1:0] em, ei;
        for (int i = 0; i < N; i++) begin
            em[i] = (i == m_sel) ? bus.mcu_miso : 1'b1;
            ei[i] = (i == m_sel) ? bus.mcu_intn : 1'b1;
        end
        chk("sel", sel, m_sel);
        chk("switched", switched, m_sw);
        chk("mcu_csn", bus.mcu_csn, bus.src_csn[m_sel] | m_blank);
        chk("sclk_mosi", {bus.mcu_sclk, bus.mcu_mosi}, {bus.src_sclk[m_sel], bus.src_mosi[m_sel]});
        chk("src_miso", bus.src_miso, em);
        chk("src_intn", bus.src_intn, ei);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk32);
            mdl_edge();
            @(negedge clk32);
            mdl_check();
        end
    endtask

    initial begin
        bus.src_csn  = '1;
        bus.src_sclk = '0;
        bus.src_mosi = '0;
        bus.mcu_miso = 1'b0;
        bus.mcu_intn = 1'b1;
        mdl_reset();
        #1;
        chk("rst_sel", sel, 0);
        chk("rst_switched", switched, 0);
        chk("rst_mcu_csn", bus.mcu_csn, 1);
        step(2);
        por = 1'b0;
        step(3);

        // 1: claim by source 1, claiming transfer is masked
        bus.src_csn[1] = 1'b0; step(10);
        chk("t1_sel", sel, 1);
        chk("t1_mask", bus.mcu_csn, 1);
        bus.src_csn[1] = 1'b1; step(6);

        // 5: idle timeout, restarted by a one-cycle low
        step(8);
        bus.src_csn[1] = 1'b0; step(1);
        bus.src_csn[1] = 1'b1; step(12);
        chk("t5_restart", sel, 1);
        step(6);
        chk("t5_revert", sel, 0);
        step(3);

        // 2: short low does not claim
        bus.src_csn[1] = 1'b0; step(3);
        bus.src_csn[1] = 1'b1; step(10);
        chk("t2_sel", sel, 0);

        // 3: claim waits for the active transfer to finish
        bus.src_csn[0] = 1'b0; step(3);
        bus.src_csn[1] = 1'b0; step(10);
        chk("t3_hold", sel, 0);
        bus.src_csn[0] = 1'b1; step(4);
        chk("t3_sel", sel, 1);
        bus.src_csn[1] = 1'b1; step(6);
        step(20);
        chk("t3_revert", sel, 0);

        // 4: simultaneous claims -> highest index, then a later claim
        bus.src_csn[1] = 1'b0; bus.src_csn[3] = 1'b0; step(9);
        chk("t4_hi", sel, 3);
        bus.src_csn[1] = 1'b1; bus.src_csn[3] = 1'b1; step(4);
        bus.src_csn[2] = 1'b0; step(10);
        chk("t4_sel2", sel, 2);
        bus.src_csn[2] = 1'b1; step(25);
        chk("t4_revert", sel, 0);

        // 6: por in the middle of a masked transfer
        bus.src_csn[2] = 1'b0; step(9);
        chk("t6_pre_sel", sel, 2);
        chk("t6_pre_mask", bus.mcu_csn, 1);
        #2 por = 1'b1;
        #1;
        chk("t6_async_sel", sel, 0);
        chk("t6_async_sw", switched, 0);
        chk("t6_async_csn", bus.mcu_csn, 1);
        mdl_reset();
        step(1);
        por = 1'b0;
        bus.src_csn[2] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            bus.mcu_miso = ~bus.mcu_miso;
            step(1);
        end
        bus.mcu_miso = 1'b1;
        #1 chk("t6_miso", bus.src_miso, 4'b1111);
        bus.mcu_miso = 1'b0;
        #1 chk("t6_miso_lo", bus.src_miso, 4'b1110);

        // Random traffic with sticky csn levels
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 11) == 0) bus.src_csn[i] = ~bus.src_csn[i];
            bus.src_sclk = N'($urandom);
            bus.src_mosi = N'($urandom);
            bus.mcu_miso = 1'($urandom);
            bus.mcu_intn = 1'($urandom);
            step(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
